// File: rtl/spi_sensor_slave_if.sv
// spi_sensor_slave_if: SPI pins plus the sensor slave's status outputs.
interface spi_sensor_slave_if;
  logic       cs_i;
  logic       sclk_i;
  logic       mosi_i;
  logic       miso_o;
  logic       frame_active_o;
  logic       byte_valid_o;
  logic [7:0] rx_byte_o;
  logic       frame_err_o;
  logic [7:0] cfg_o;
  modport slave (
    input  cs_i, sclk_i, mosi_i,
    output miso_o, frame_active_o, byte_valid_o, rx_byte_o, frame_err_o, cfg_o
  );
  modport master (
    output cs_i, sclk_i, mosi_i,
    input  miso_o, frame_active_o, byte_valid_o, rx_byte_o, frame_err_o, cfg_o
  );
endinterface

// File: rtl/spi_sensor_slave.sv
// spi_sensor_slave: mode-0 SPI slave exposing an 8x8 register map with ID, config and sample snapshot.
module spi_sensor_slave #(
  parameter logic [7:0] DEV_ID      = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  spi_sensor_slave_if.slave bus_if
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic        cs_e_q, sclk_e_q;
  logic [2:0]  bit_cnt_q, addr_q, rd_addr;
  logic [7:0]  rx_shift_q, tx_shift_q, rx_byte_q, rd_data, rx_next;
  logic [7:0]  r1_q, r2_q, r3_q, frame_cnt_q;
  logic [15:0] cnt_q, snap_q;
  logic        last_err_q, read_q, cmd_done_q, byte_done_q, byte_valid_q, frame_err_q;
  logic        cs_s, sclk_s, mosi_s, cs_fall, cs_rise, active, sclk_rise, sclk_fall;
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_e_q & ~cs_s;
  assign cs_rise   = ~cs_e_q & cs_s;
  assign active    = state_q != IDLE;
  // sclk edges coinciding with the end of a frame must not disturb the byte counter
  assign sclk_rise = active & ~cs_rise & ~sclk_e_q & sclk_s;
  assign sclk_fall = active & ~cs_rise & sclk_e_q & ~sclk_s;
  assign rx_next   = {rx_shift_q[6:0], mosi_s};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_e_q      <= 1'b1;
      sclk_e_q    <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus_if.cs_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus_if.sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_if.mosi_i};
      cs_e_q      <= cs_s;
      sclk_e_q    <= sclk_s;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cs_fall ? CMD : IDLE;
      CMD:     state_d = cs_rise ? IDLE : (sclk_rise && bit_cnt_q == 3'd7) ? DATA : CMD;
      DATA:    state_d = cs_rise ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus_if.frame_active_o = active;
    bus_if.miso_o         = ~bus_if.cs_i & (state_q == DATA) & read_q & tx_shift_q[7];
  end
  // command byte addresses its own start register; data bytes fetch the following one
  always_comb begin
    rd_addr = (state_q == CMD) ? rx_next[2:0] : addr_q + 3'd1;
    case (rd_addr)
      3'd0:    rd_data = DEV_ID;
      3'd1:    rd_data = r1_q;
      3'd2:    rd_data = r2_q;
      3'd3:    rd_data = r3_q;
      3'd4:    rd_data = snap_q[15:8];
      3'd5:    rd_data = snap_q[7:0];
      3'd6:    rd_data = frame_cnt_q;
      default: rd_data = {7'b0, last_err_q};
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      addr_q       <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      rx_byte_q    <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      r3_q         <= '0;
      frame_cnt_q  <= '0;
      last_err_q   <= 1'b0;
      cnt_q        <= '0;
      snap_q       <= '0;
      read_q       <= 1'b0;
      cmd_done_q   <= 1'b0;
      byte_done_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + 16'd1;
      byte_done_q  <= 1'b0;
      byte_valid_q <= byte_done_q;
      frame_err_q  <= 1'b0;
      if (byte_done_q) rx_byte_q <= rx_shift_q;
      if (cs_fall) begin
        snap_q     <= cnt_q;
        bit_cnt_q  <= '0;
        cmd_done_q <= 1'b0;
      end
      if (sclk_rise) begin
        rx_shift_q <= rx_next;
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_q <= 1'b1;
          tx_shift_q  <= rd_data;
          if (state_q == CMD) begin
            read_q     <= rx_next[7];
            addr_q     <= rx_next[2:0];
            cmd_done_q <= 1'b1;
          end else begin
            if (!read_q && addr_q == 3'd1) r1_q <= rx_next;
            if (!read_q && addr_q == 3'd2) r2_q <= rx_next;
            if (!read_q && addr_q == 3'd3) r3_q <= rx_next;
            addr_q <= addr_q + 3'd1;
          end
        end
      end
      if (sclk_fall && state_q == DATA && read_q && bit_cnt_q != 3'd0)
        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
      if (cs_rise && active) begin
        bit_cnt_q   <= '0;
        cmd_done_q  <= 1'b0;
        frame_err_q <= bit_cnt_q != 3'd0;
        last_err_q  <= bit_cnt_q != 3'd0;
        if (cmd_done_q) frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end
  assign bus_if.byte_valid_o = byte_valid_q;
  assign bus_if.rx_byte_o    = rx_byte_q;
  assign bus_if.frame_err_o  = frame_err_q;
  assign bus_if.cfg_o        = r1_q;
endmodule
